// File: rtl/fir_engine_ctrl.sv
// rtl/fir_engine_ctrl.sv - FIR engine sequencer: buffer clear, sample capture, tap MAC sweep, output handshake
module fir_engine_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   ap_start_set,
    input  logic [pDATA_WIDTH-1:0] data_length,
    input  logic                   ss_tvalid,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic                   sm_tlast,
    output logic                   ap_start,
    output logic                   ap_done,
    output logic                   ap_idle,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic                   data_EN,
    output logic [3:0]             data_WE,
    output logic                   data_zero,
    output logic                   acc_clr,
    output logic                   acc_en
);

    localparam int CW = $clog2(Tape_Num + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WAIT_IN, S_MAC, S_OUT, S_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [CW-1:0]          wp, wp_nxt;
    logic [pDATA_WIDTH-1:0] out_cnt, out_cnt_nxt;
    logic                   last_q, last_nxt;
    logic [CW-1:0]          rd_idx;
    logic                   is_last;

    function automatic logic [pADDR_WIDTH-1:0] byte_addr(input logic [CW-1:0] idx);
        return pADDR_WIDTH'(idx) << 2;
    endfunction

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            wp      <= '0;
            out_cnt <= '0;
            last_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            wp      <= wp_nxt;
            out_cnt <= out_cnt_nxt;
            last_q  <= last_nxt;
        end
    end

    // Circular buffer walk: newest sample at wp, older samples behind it.
    always_comb begin
        rd_idx = '0;
        if (wp >= cnt) rd_idx = wp - cnt;
        else           rd_idx = wp + CW'(Tape_Num) - cnt;
    end

    assign is_last = (out_cnt + pDATA_WIDTH'(1) == data_length) || last_q;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        wp_nxt      = wp;
        out_cnt_nxt = out_cnt;
        last_nxt    = last_q;
        ss_tready   = 1'b0;
        sm_tvalid   = 1'b0;
        sm_tlast    = 1'b0;
        ap_start    = 1'b0;
        ap_done     = 1'b0;
        ap_idle     = 1'b0;
        tap_A       = '0;
        data_A      = '0;
        data_EN     = 1'b0;
        data_WE     = 4'h0;
        data_zero   = 1'b0;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                ap_idle = 1'b1;
                ap_done = (state == S_DONE);
                if (ap_start_set) begin
                    ap_start    = 1'b1;
                    state_nxt   = S_CLEAR;
                    cnt_nxt     = '0;
                    wp_nxt      = '0;
                    out_cnt_nxt = '0;
                    last_nxt    = 1'b0;
                end
            end
            S_CLEAR: begin
                data_EN   = 1'b1;
                data_WE   = 4'hF;
                data_zero = 1'b1;
                data_A    = byte_addr(cnt);
                if (cnt == CW'(Tape_Num - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = (data_length == '0) ? S_DONE : S_WAIT_IN;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_WAIT_IN: begin
                ss_tready = 1'b1;
                data_A    = byte_addr(wp);
                if (ss_tvalid) begin
                    data_EN   = 1'b1;
                    data_WE   = 4'hF;
                    acc_clr   = 1'b1;
                    last_nxt  = ss_tlast;
                    cnt_nxt   = '0;
                    state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                // Reads issue at c=0..N-1; the accumulate lags one cycle behind the BRAM.
                if (cnt < CW'(Tape_Num)) begin
                    tap_A   = byte_addr(cnt);
                    data_A  = byte_addr(rd_idx);
                    data_EN = 1'b1;
                end
                acc_en = (cnt != '0);
                if (cnt == CW'(Tape_Num)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_OUT;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_OUT: begin
                sm_tvalid = 1'b1;
                sm_tlast  = is_last;
                if (sm_tready) begin
                    wp_nxt      = (wp == CW'(Tape_Num - 1)) ? '0 : wp + CW'(1);
                    out_cnt_nxt = out_cnt + pDATA_WIDTH'(1);
                    state_nxt   = is_last ? S_DONE : S_WAIT_IN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fir_engine_ctrl.sv
// tb/tb_fir_engine_ctrl.sv - directed self-checking bench for fir_engine_ctrl
module tb_fir_engine_ctrl;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n;
    logic        ap_start_set;
    logic [31:0] data_length;
    logic        ss_tvalid, ss_tlast, ss_tready;
    logic        sm_tready, sm_tvalid, sm_tlast;
    logic        ap_start, ap_done, ap_idle;
    logic [11:0] tap_A, data_A;
    logic        data_EN;
    logic [3:0]  data_WE;
    logic        data_zero, acc_clr, acc_en;

    int passed = 0;
    int total  = 0;

    fir_engine_ctrl dut (
        .axis_clk     (axis_clk),
        .axis_rst_n   (axis_rst_n),
        .ap_start_set (ap_start_set),
        .data_length  (data_length),
        .ss_tvalid    (ss_tvalid),
        .ss_tlast     (ss_tlast),
        .ss_tready    (ss_tready),
        .sm_tready    (sm_tready),
        .sm_tvalid    (sm_tvalid),
        .sm_tlast     (sm_tlast),
        .ap_start     (ap_start),
        .ap_done      (ap_done),
        .ap_idle      (ap_idle),
        .tap_A        (tap_A),
        .data_A       (data_A),
        .data_EN      (data_EN),
        .data_WE      (data_WE),
        .data_zero    (data_zero),
        .acc_clr      (acc_clr),
        .acc_en       (acc_en)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic test_reset();
        axis_rst_n   = 1'b0;
        ap_start_set = 1'b0;
        data_length  = 32'd0;
        ss_tvalid    = 1'b0;
        ss_tlast     = 1'b0;
        sm_tready    = 1'b0;
        repeat (3) @(posedge axis_clk);
        #1;
        total++;
        if ({ap_idle, ap_start, ap_done, ss_tready, sm_tvalid, sm_tlast, data_EN, data_zero, acc_en, acc_clr} !== 10'b1000000000)
            $display("FAIL reset_flags got %b want 1000000000",
                     {ap_idle, ap_start, ap_done, ss_tready, sm_tvalid, sm_tlast, data_EN, data_zero, acc_en, acc_clr});
        else passed++;
        total++;
        if ({data_WE, tap_A, data_A} !== 28'd0)
            $display("FAIL reset_addr we=%h tap_A=%0d data_A=%0d want 0", data_WE, tap_A, data_A);
        else passed++;
        axis_rst_n = 1'b1;
        step();
        total++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0)
            $display("FAIL idle_after_reset idle=%b done=%b want 1/0", ap_idle, ap_done);
        else passed++;
    endtask

    task automatic do_start(input logic [31:0] len);
        data_length  = len;
        ap_start_set = 1'b1;
        #1;
        total++;
        if (ap_start !== 1'b1) $display("FAIL start_pulse ap_start=%b want 1", ap_start);
        else passed++;
        step();
        ap_start_set = 1'b0;
        #1;
        total++;
        if (ap_start !== 1'b0 || ap_done !== 1'b0 || ap_idle !== 1'b0)
            $display("FAIL start_width start=%b done=%b idle=%b want 0/0/0", ap_start, ap_done, ap_idle);
        else passed++;
        for (int i = 0; i < 11; i++) begin
            total++;
            if ({data_EN, data_WE, data_zero} !== 6'b111111 || data_A !== 12'(4 * i))
                $display("FAIL clear[%0d] en/we/zero=%b data_A=%0d want 111111 and %0d",
                         i, {data_EN, data_WE, data_zero}, data_A, 4 * i);
            else passed++;
            step();
        end
    endtask

    task automatic do_sample(input int exp_wp, input logic tlast_in, input logic exp_tlast,
                             input int stall, input logic start_in_mac);
        int n = 0;
        while (!ss_tready && n < 30) begin
            step();
            n++;
        end
        total++;
        if (ss_tready !== 1'b1) begin
            $display("FAIL wait_ready ss_tready=%b want 1 within 30 cycles", ss_tready);
            return;
        end
        passed++;
        ss_tvalid = 1'b1;
        ss_tlast  = tlast_in;
        #1;
        total++;
        if (data_A !== 12'(4 * exp_wp) || data_WE !== 4'hF || data_EN !== 1'b1 ||
            acc_clr !== 1'b1 || data_zero !== 1'b0)
            $display("FAIL sample_write data_A=%0d we=%h en=%b clr=%b zero=%b want %0d/f/1/1/0",
                     data_A, data_WE, data_EN, acc_clr, data_zero, 4 * exp_wp);
        else passed++;
        step();
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
        for (int c = 0; c < 12; c++) begin
            int ea = (c < 11) ? 4 * ((exp_wp - c + 11) % 11) : 0;
            int et = (c < 11) ? 4 * c : 0;
            ap_start_set = start_in_mac && (c == 3);
            #1;
            total++;
            if (tap_A !== 12'(et) || data_A !== 12'(ea) || data_EN !== (c < 11) ||
                data_WE !== 4'h0 || acc_en !== (c >= 1) || acc_clr !== 1'b0 ||
                ss_tready !== 1'b0 || ap_start !== 1'b0)
                $display("FAIL mac[%0d] tap_A=%0d data_A=%0d en=%b we=%h acc_en=%b rdy=%b start=%b want %0d/%0d/%b/0/%b/0/0",
                         c, tap_A, data_A, data_EN, data_WE, acc_en, ss_tready, ap_start,
                         et, ea, (c < 11), (c >= 1));
            else passed++;
            step();
        end
        ap_start_set = 1'b0;
        for (int s = 0; s < stall; s++) begin
            total++;
            if (sm_tvalid !== 1'b1 || ss_tready !== 1'b0 || acc_en !== 1'b0)
                $display("FAIL out_stall[%0d] tvalid=%b ss_tready=%b acc_en=%b want 1/0/0",
                         s, sm_tvalid, ss_tready, acc_en);
            else passed++;
            step();
        end
        sm_tready = 1'b1;
        #1;
        total++;
        if (sm_tvalid !== 1'b1 || sm_tlast !== exp_tlast || ss_tready !== 1'b0)
            $display("FAIL out_handshake tvalid=%b tlast=%b ss_tready=%b want 1/%b/0",
                     sm_tvalid, sm_tlast, ss_tready, exp_tlast);
        else passed++;
        step();
        sm_tready = 1'b0;
    endtask

    task automatic check_done(input string tag);
        total++;
        if (ap_done !== 1'b1 || ap_idle !== 1'b1 || ss_tready !== 1'b0 || sm_tvalid !== 1'b0)
            $display("FAIL %s done=%b idle=%b ss_tready=%b sm_tvalid=%b want 1/1/0/0",
                     tag, ap_done, ap_idle, ss_tready, sm_tvalid);
        else passed++;
    endtask

    task automatic test_basic();
        do_start(32'd3);
        do_sample(0, 1'b0, 1'b0, 0, 1'b0);
        do_sample(1, 1'b0, 1'b0, 0, 1'b0);
        do_sample(2, 1'b0, 1'b1, 0, 1'b0);
        check_done("basic_done");
        step();
        step();
        check_done("basic_done_hold");
    endtask

    task automatic test_backpressure();
        do_start(32'd1);
        do_sample(0, 1'b0, 1'b1, 5, 1'b0);
        check_done("bp_done");
    endtask

    task automatic test_wrap();
        do_start(32'd12);
        for (int k = 0; k < 12; k++)
            do_sample(k % 11, 1'b0, (k == 11), 0, 1'b0);
        check_done("wrap_done");
    endtask

    task automatic test_early_last();
        do_start(32'd5);
        do_sample(0, 1'b0, 1'b0, 0, 1'b1);
        do_sample(1, 1'b1, 1'b1, 0, 1'b0);
        check_done("early_last_done");
    endtask

    task automatic test_zero_len();
        do_start(32'd0);
        check_done("zero_len_done");
    endtask

    task automatic test_mid_mac_reset();
        do_start(32'd2);
        ss_tvalid = 1'b1;
        #1;
        step();
        ss_tvalid = 1'b0;
        step();
        step();
        total++;
        if (data_EN !== 1'b1 || acc_en !== 1'b1)
            $display("FAIL pre_reset_mac en=%b acc_en=%b want 1/1", data_EN, acc_en);
        else passed++;
        #2;
        axis_rst_n = 1'b0;
        #1;
        total++;
        if (ap_idle !== 1'b1 || sm_tvalid !== 1'b0 || ss_tready !== 1'b0 ||
            data_EN !== 1'b0 || acc_en !== 1'b0 || tap_A !== 12'd0)
            $display("FAIL mid_mac_reset idle=%b sm_tvalid=%b ss_tready=%b en=%b acc_en=%b tap_A=%0d want 1/0/0/0/0/0",
                     ap_idle, sm_tvalid, ss_tready, data_EN, acc_en, tap_A);
        else passed++;
        step();
        axis_rst_n = 1'b1;
        step();
        total++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0)
            $display("FAIL post_reset_idle idle=%b done=%b want 1/0", ap_idle, ap_done);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_early_last();
        test_zero_len();
        test_mid_mac_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
